// File: rtl/apb_arbiter_if.sv
`default_nettype none
// =====================================================================
// Module   : apb_arbiter_if
// Desc     : One APB link (requester <-> completer) used on every arbiter port.
// Revision : 1.0 - initial release
// =====================================================================
interface apb_arbiter_if #(
    parameter int ADDR_W = 32
);
    logic              psel;
    logic              penable;
    logic              pready;
    logic [ADDR_W-1:0] paddr;
    logic              pwrite;
    logic [31:0]       pwdata;
    logic [3:0]        pwstrb;
    logic [31:0]       prdata;
    logic              pslverr;

    modport master (
        output psel, penable, paddr, pwrite, pwdata, pwstrb,
        input  pready, prdata, pslverr
    );

    modport slave (
        input  psel, penable, paddr, pwrite, pwdata, pwstrb,
        output pready, prdata, pslverr
    );
endinterface
`default_nettype wire

// File: rtl/apb_arbiter.sv
`default_nettype none
// =====================================================================
// Module   : apb_arbiter
// Desc     : Two-requester round-robin APB arbiter in front of one fabric port.
//            Define APB_ARB_TIMEOUT_EN to enable the ACCESS-phase watchdog.
// Revision : 1.0 - initial release
// =====================================================================
module apb_arbiter #(
    parameter int ADDR_W         = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  wire logic     clk,
    input  wire logic     rst,
    apb_arbiter_if.slave  r0_i,
    apb_arbiter_if.slave  r1_i,
    apb_arbiter_if.master fab_t
);
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic        r_grant;
    logic        r_last;
    logic        w_grant_nxt;
    logic        w_last_nxt;
    logic        w_req_any;
    logic        w_winner;
    logic        w_done;
    logic        w_timeout;
    logic        w_resp;
    logic        w_gnt_psel;
    logic        w_ack;
    logic [31:0] w_rdata;
    logic        w_err;

    assign w_req_any = r0_i.psel | r1_i.psel;

    // On a tie the requester that did not win last time takes the bus.
    always_comb begin
        w_winner = r1_i.psel;
        if (r0_i.psel && r1_i.psel) begin
            w_winner = ~r_last;
        end
    end

`ifdef APB_ARB_TIMEOUT_EN
    localparam int c_cnt_raw = $clog2(TIMEOUT_CYCLES + 1);
    localparam int c_cnt_w   = (c_cnt_raw < 8) ? 8 : ((c_cnt_raw > 32) ? 32 : c_cnt_raw);
    localparam logic [c_cnt_w-1:0] c_timeout = c_cnt_w'(TIMEOUT_CYCLES);

    logic [c_cnt_w-1:0] r_wd_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wd_cnt <= '0;
        end else if (r_state == ST_IDLE && w_req_any) begin
            r_wd_cnt <= '0;
        end else if (r_state == ST_ACCESS && !fab_t.pready) begin
            r_wd_cnt <= r_wd_cnt + c_cnt_w'(1);
        end
    end

    // A fabric pready in the same cycle takes precedence over the watchdog.
    assign w_timeout = (r_state == ST_ACCESS) && !fab_t.pready && (r_wd_cnt == c_timeout);
`else
    localparam int c_unused_timeout = TIMEOUT_CYCLES;
    assign w_timeout = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_grant <= 1'b0;
            r_last  <= 1'b1;
        end else begin
            r_state <= w_state_nxt;
            r_grant <= w_grant_nxt;
            r_last  <= w_last_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_grant_nxt = r_grant;
        w_last_nxt  = r_last;
        case (r_state)
            ST_IDLE: begin
                if (w_req_any) begin
                    w_state_nxt = ST_SETUP;
                    w_grant_nxt = w_winner;
                    w_last_nxt  = w_winner;
                end
            end
            ST_SETUP:  w_state_nxt = ST_ACCESS;
            ST_ACCESS: begin
                if (fab_t.pready || w_timeout) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default:   w_state_nxt = ST_IDLE;
        endcase
    end

    assign fab_t.psel    = (r_state != ST_IDLE);
    assign fab_t.penable = (r_state == ST_ACCESS);
    assign fab_t.paddr   = r_grant ? r1_i.paddr  : r0_i.paddr;
    assign fab_t.pwrite  = r_grant ? r1_i.pwrite : r0_i.pwrite;
    assign fab_t.pwdata  = r_grant ? r1_i.pwdata : r0_i.pwdata;
    assign fab_t.pwstrb  = r_grant ? r1_i.pwstrb : r0_i.pwstrb;

    // A requester that abandoned its transfer gets nothing back.
    assign w_done     = (r_state == ST_ACCESS) && fab_t.pready;
    assign w_resp     = w_done | w_timeout;
    assign w_gnt_psel = r_grant ? r1_i.psel : r0_i.psel;
    assign w_ack      = w_resp && w_gnt_psel;
    assign w_rdata    = w_done ? fab_t.prdata : 32'd0;
    assign w_err      = w_done ? fab_t.pslverr : w_timeout;

    assign r0_i.pready  = w_ack && !r_grant;
    assign r0_i.prdata  = (w_ack && !r_grant) ? w_rdata : 32'd0;
    assign r0_i.pslverr = w_ack && !r_grant && w_err;
    assign r1_i.pready  = w_ack && r_grant;
    assign r1_i.prdata  = (w_ack && r_grant) ? w_rdata : 32'd0;
    assign r1_i.pslverr = w_ack && r_grant && w_err;

    logic w_unused;
    assign w_unused = &{1'b0, r0_i.penable, r1_i.penable};
endmodule
`default_nettype wire

// File: doc/apb_arbiter.md
# apb_arbiter

Two-requester APB arbiter placed in front of the APB address-decode fabric, so that two initiators (instruction-fetch port and data port of the core) share a single fabric initiator port. It behaves as an APB completer toward each requester and as an APB requester toward the fabric. It regenerates a clean SETUP/ACCESS sequence for the granted requester and returns the fabric response to that requester only. Round-robin arbitration is applied on simultaneous requests.

## Interface
Parameters:
- ADDR_W, 32, address width on all ports
- TIMEOUT_CYCLES, 255, ACCESS-phase watchdog limit; used only when APB_ARB_TIMEOUT_EN is defined

Ports:
- clk  in  1  clock
- rst  in  1  reset; one clock, reset is synchronous and active-high
- r0_i_psel / r0_i_penable  in  1  requester 0 select / enable
- r0_i_pready  out  1  requester 0 transfer complete
- r0_i_paddr  in  ADDR_W  requester 0 address
- r0_i_pwrite  in  1  requester 0 write
- r0_i_pwdata  in  32  requester 0 write data
- r0_i_pwstrb  in  4  requester 0 byte strobes
- r0_i_prdata  out  32  requester 0 read data
- r0_i_pslverr  out  1  requester 0 error
- r1_i_*  (same set, same directions and widths)  requester 1
- fab_t_psel / fab_t_penable  out  1  fabric select / enable
- fab_t_pready  in  1  fabric complete
- fab_t_paddr  out  ADDR_W  fabric address
- fab_t_pwrite  out  1  fabric write
- fab_t_pwdata  out  32  fabric write data
- fab_t_pwstrb  out  4  fabric byte strobes
- fab_t_prdata  in  32  fabric read data
- fab_t_pslverr  in  1  fabric error

## Operation
- FSM states: IDLE, SETUP, ACCESS. Registers: state, grant (1 bit), last (1 bit).
- IDLE:
  - If r0_i_psel or r1_i_psel is high, load grant and set last = winner, then go to SETUP.
  - If only one requester is asserting, it wins.
  - If both are asserting, the winner is the requester that is not `last`.
  - If neither is asserting, stay in IDLE.
- SETUP: fab_t_psel=1, fab_t_penable=0. Next state is ACCESS, unconditionally.
- ACCESS: fab_t_psel=1, fab_t_penable=1.
  - When fab_t_pready=1, the granted requester sees pready=1 in the same cycle, with prdata and pslverr passed through combinationally.
  - The FSM then returns to IDLE.
- fab_t_paddr, fab_t_pwrite, fab_t_pwdata and fab_t_pwstrb are muxed combinationally from the requester selected by `grant`, in every state.
- Requester outputs:
  - The non-granted requester sees pready=0, prdata=0 and pslverr=0.
  - The granted requester also sees all three at 0 outside its completing ACCESS cycle.
- The requester's own penable is ignored. The arbiter regenerates the phases itself. A requester waits in its ACCESS phase with its signals held stable, as APB requires.
- If the granted requester drops psel mid-transfer (protocol violation), the fabric transfer still completes and the response is discarded. No stall or lockup occurs.
- Reset: state=IDLE, grant=0, last=1, so requester 0 wins the first tie. At reset, fab_t_psel=0, fab_t_penable=0, and all requester pready/pslverr/prdata outputs are 0.
- rst asserted mid-transfer aborts it: fab_t_psel drops at the next edge and no pready is issued.

## Timing
- The requester asserts psel in cycle t.
  - t+1: SETUP.
  - t+2: ACCESS.
  - Earliest requester pready is at t+2, which is one cycle more than a direct fabric connection.
- After completion there is one mandatory IDLE cycle. Back-to-back transfers from one requester therefore cost 3 cycles minimum.
- Under continuous contention, grants strictly alternate: 0,1,0,1...
- Fabric wait states extend ACCESS one-for-one.
- A request arriving during SETUP or ACCESS waits for IDLE. It is never dropped, because psel is held by the requester.

## Configuration
- APB_ARB_TIMEOUT_EN defined:
  - An 8..32-bit counter, sized by $clog2(TIMEOUT_CYCLES+1), clears on SETUP entry and increments each ACCESS cycle with fab_t_pready=0.
  - When the count reaches TIMEOUT_CYCLES without pready, the granted requester gets pready=1, pslverr=1 and prdata=0 for one cycle.
  - fab_t_psel drops and the FSM goes to IDLE.
  - A fabric pready in the same cycle as the timeout wins: the normal response is returned.
- Not defined: no counter. ACCESS waits indefinitely for fab_t_pready, and TIMEOUT_CYCLES is ignored.

## Test plan
- Single read: r0 reads 0x8000_0004, fabric pready immediate with prdata=0xDEADBEEF. Required: fab SETUP at t+1, ACCESS at t+2, r0_i_prdata=0xDEADBEEF with pready at t+2, r1 outputs stay 0.
- Tie after reset: r0 and r1 assert psel in the same cycle. Required: r0 is granted first and r1 second. Held requests then alternate 0,1,0,1 across 4 transfers.
- Wait states: r1 writes 0x0000_0100 with pwdata=0x12345678 and pwstrb=0x3, fabric pready after 3 wait cycles. Required: fabric address, data and strobe stable throughout; r1 pready lasts exactly 1 cycle.
- Error passthrough: fabric pslverr=1 on a read. Required: granted requester sees pslverr=1 and pready=1 in the same cycle; the other requester sees 0.
- Reset mid-ACCESS: assert rst during a wait state. Required: fab_t_psel=0 at the next edge, no requester pready, and the next tie grants r0.
- With APB_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=4, fabric never ready. Required: requester pready=1 with pslverr=1 and prdata=0 after the 4th ACCESS cycle, then the FSM is IDLE.
